// File: rtl/hdr_ddr_payload_fetch.sv
// hdr_ddr_payload_fetch
// Fetches a decoded descriptor's payload out of the target register file,
// two bytes per HDR-DDR data word, and presents each 16-bit word (first byte
// in [15:8]) to the DDR serializer. An odd trailing byte is padded with 0x00.
//
// Handshake: o_fetch_valid rises in PRESENT and stays high, with o_fetch_word,
// o_fetch_last and o_fetch_odd held stable, until the clock edge where
// i_fetch_ready is also high; that edge transfers the word. Ready while valid
// is low has no effect.
//
// dbg_state: 0 IDLE, 1 RD_LO, 2 RD_HI, 3 CAP, 4 PRESENT, 5 DONE.

module hdr_ddr_payload_fetch #(
    parameter int WIDTH = 8,
    parameter int ADDR  = 12,
    parameter int LEN_W = 16
) (
    input  logic             i_fetch_clk,
    input  logic             i_fetch_rst_n,
    input  logic             i_fetch_start,
    input  logic             i_fetch_abort,
    input  logic [ADDR-1:0]  i_fetch_base_addr,
    input  logic [LEN_W-1:0] i_frmcnt_data_len,
    input  logic [2:0]       i_frmcnt_DTT,
    output logic             o_regf_rd_en,
    output logic [ADDR-1:0]  o_regf_addr,
    input  logic [WIDTH-1:0] i_regf_data_rd,
    output logic [15:0]      o_fetch_word,
    output logic             o_fetch_valid,
    input  logic             i_fetch_ready,
    output logic             o_fetch_last,
    output logic             o_fetch_odd,
    output logic             o_fetch_busy,
    output logic             o_fetch_done,
    output logic [2:0]       dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_RD_LO   = 3'd1,
        S_RD_HI   = 3'd2,
        S_CAP     = 3'd3,
        S_PRESENT = 3'd4,
        S_DONE    = 3'd5
    } state_t;

    localparam logic [LEN_W:0] ONE = {{LEN_W{1'b0}}, 1'b1};
    localparam logic [LEN_W:0] TWO = ONE + ONE;

    state_t           state;
    state_t           state_n;
    logic [ADDR-1:0]  base_q;
    logic [LEN_W-1:0] len_q;
    logic [LEN_W-1:0] idx_q;
    logic [15:0]      word_q;
    logic             odd_q;

    logic [LEN_W-1:0] len_eff;
    logic [7:0]       rd_byte;
    logic [LEN_W:0]   idx_x;
    logic [LEN_W:0]   len_x;
    logic [LEN_W:0]   idx_p1;
    logic [LEN_W:0]   idx_p2;
    logic             more_hi;
    logic             all_sent;
    logic             start_take;

    // A zero data-length field means a short transfer sized by DTT.
    assign len_eff    = (i_frmcnt_data_len != '0) ? i_frmcnt_data_len : LEN_W'(i_frmcnt_DTT);
    assign rd_byte    = 8'(i_regf_data_rd);
    // Index comparisons carry one extra bit so idx+1 and idx+2 never wrap.
    assign idx_x      = {1'b0, idx_q};
    assign len_x      = {1'b0, len_q};
    assign idx_p1     = idx_x + ONE;
    assign idx_p2     = idx_x + TWO;
    assign more_hi    = (idx_p1 < len_x);
    assign all_sent   = (idx_x >= len_x);
    assign start_take = (state == S_IDLE) && i_fetch_start && !i_fetch_abort;

    assign o_fetch_word = word_q;
    assign dbg_state    = state;

    // State register.
    always_ff @(posedge i_fetch_clk or negedge i_fetch_rst_n) begin
        if (!i_fetch_rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next-state logic; abort wins over ready and start.
    always_comb begin
        state_n = state;
        if (i_fetch_abort) begin
            state_n = S_IDLE;
        end else begin
            case (state)
                S_IDLE:    if (i_fetch_start) state_n = (len_eff != '0) ? S_RD_LO : S_DONE;
                S_RD_LO:   state_n = more_hi ? S_RD_HI : S_CAP;
                S_RD_HI:   state_n = S_CAP;
                S_CAP:     state_n = S_PRESENT;
                S_PRESENT: if (i_fetch_ready) state_n = all_sent ? S_DONE : S_RD_LO;
                S_DONE:    state_n = S_IDLE;
                default:   state_n = S_IDLE;
            endcase
        end
    end

    // Transfer context, byte index and word assembly from read-port data.
    always_ff @(posedge i_fetch_clk or negedge i_fetch_rst_n) begin
        if (!i_fetch_rst_n) begin
            base_q <= '0;
            len_q  <= '0;
            idx_q  <= '0;
            word_q <= '0;
            odd_q  <= 1'b0;
        end else if (start_take) begin
            base_q <= i_fetch_base_addr;
            len_q  <= len_eff;
            idx_q  <= '0;
            odd_q  <= 1'b0;
        end else begin
            case (state)
                S_RD_LO: odd_q <= !more_hi;
                S_RD_HI: word_q[15:8] <= rd_byte;
                S_CAP: begin
                    if (odd_q) begin
                        word_q <= {rd_byte, 8'h00};
                    end else begin
                        word_q[7:0] <= rd_byte;
                    end
                    idx_q <= (idx_p2 > len_x) ? len_q : idx_p2[LEN_W-1:0];
                end
                default: ;
            endcase
        end
    end

    // Outputs decoded from the current state.
    always_comb begin
        o_regf_rd_en  = 1'b0;
        o_regf_addr   = '0;
        o_fetch_valid = 1'b0;
        o_fetch_last  = 1'b0;
        o_fetch_odd   = 1'b0;
        o_fetch_done  = 1'b0;
        o_fetch_busy  = (state != S_IDLE);
        case (state)
            S_RD_LO: begin
                o_regf_rd_en = 1'b1;
                o_regf_addr  = base_q + ADDR'(idx_q);
            end
            S_RD_HI: begin
                o_regf_rd_en = 1'b1;
                o_regf_addr  = base_q + ADDR'(idx_q) + ADDR'(1);
            end
            S_PRESENT: begin
                o_fetch_valid = 1'b1;
                o_fetch_last  = all_sent;
                o_fetch_odd   = all_sent && len_q[0];
            end
            S_DONE: o_fetch_done = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_hdr_ddr_payload_fetch.sv
// Testbench for hdr_ddr_payload_fetch: a register-file byte array answers the
// read port one cycle late; each transfer's expected reads and words are
// built from the payload rules and compared as the DUT produces them.

module tb_hdr_ddr_payload_fetch;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic        ready = 1'b0;
    logic [11:0] base_in = '0;
    logic [15:0] dlen = '0;
    logic [2:0]  dtt = '0;
    logic        rd_en;
    logic [11:0] rd_addr;
    logic [7:0]  rd_data = '0;
    logic [15:0] word;
    logic        valid;
    logic        last;
    logic        odd;
    logic        busy;
    logic        done;
    logic [2:0]  dbg_state;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] mem [0:4095];

    hdr_ddr_payload_fetch #(.WIDTH(8), .ADDR(12), .LEN_W(16)) dut (
        .i_fetch_clk       (clk),
        .i_fetch_rst_n     (rst_n),
        .i_fetch_start     (start),
        .i_fetch_abort     (abort),
        .i_fetch_base_addr (base_in),
        .i_frmcnt_data_len (dlen),
        .i_frmcnt_DTT      (dtt),
        .o_regf_rd_en      (rd_en),
        .o_regf_addr       (rd_addr),
        .i_regf_data_rd    (rd_data),
        .o_fetch_word      (word),
        .o_fetch_valid     (valid),
        .i_fetch_ready     (ready),
        .o_fetch_last      (last),
        .o_fetch_odd       (odd),
        .o_fetch_busy      (busy),
        .o_fetch_done      (done),
        .dbg_state         (dbg_state)
    );

    // Clock.
    always #5 clk = ~clk;

    // Register file read port: data appears the cycle after the enable.
    always @(posedge clk) begin
        if (rd_en) rd_data <= mem[rd_addr];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // mode 0: ready held high, 1: random ready, 2: ready low for 5 valid cycles per word.
    task automatic do_transfer(input logic [11:0] b, input logic [15:0] dl, input logic [2:0] dt,
                               input int mode, input bit noise);
        logic [15:0] len;
        logic [15:0] exp_q[$];
        logic [11:0] addr_q[$];
        logic [11:0] a;
        logic [15:0] ew;
        logic [15:0] held;
        logic        held_last;
        int          cyc;
        int          hs_cyc;
        int          wait_cnt;
        bit          seen_done;
        bit          holding;
        bit          r;
        bit          is_last;

        len = (dl != 16'd0) ? dl : {13'd0, dt};
        for (int i = 0; i < int'(len); i++) begin
            a = b + 12'(i);
            addr_q.push_back(a);
        end
        for (int k = 0; k < int'(len); k += 2) begin
            a = b + 12'(k);
            ew[15:8] = mem[a];
            a = b + 12'(k + 1);
            ew[7:0] = (k + 1 < int'(len)) ? mem[a] : 8'h00;
            exp_q.push_back(ew);
        end

        start = 1'b1;
        base_in = b;
        dlen = dl;
        dtt = dt;
        ready = (mode == 0);
        @(posedge clk); #1;
        start = 1'b0;
        base_in = 12'($urandom);
        dlen = 16'($urandom);
        dtt = 3'($urandom);

        cyc = 1;
        hs_cyc = 0;
        wait_cnt = 0;
        seen_done = 1'b0;
        holding = 1'b0;
        held = '0;
        held_last = 1'b0;
        while (!seen_done && cyc < 400) begin
            start = noise && (cyc == 2);
            if (rd_en) begin
                if (addr_q.size() == 0) begin
                    check("rd_extra", 32'(rd_en), 32'd0);
                end else begin
                    a = addr_q.pop_front();
                    check("rd_addr", 32'(rd_addr), 32'(a));
                end
            end
            if (valid) begin
                if (holding) begin
                    check("hold_word", 32'(word), 32'(held));
                    check("hold_last", 32'(last), 32'(held_last));
                end else if (exp_q.size() != 0) begin
                    check("valid_cycle", 32'(cyc),
                          32'(hs_cyc + ((exp_q.size() == 1 && len[0]) ? 3 : 4)));
                end
                case (mode)
                    0:       r = 1'b1;
                    1:       r = 1'($urandom_range(0, 1));
                    default: r = (wait_cnt >= 5);
                endcase
                if (r) begin
                    if (exp_q.size() == 0) begin
                        check("word_extra", 32'(valid), 32'd0);
                    end else begin
                        ew = exp_q.pop_front();
                        is_last = (exp_q.size() == 0);
                        check("word", 32'(word), 32'(ew));
                        check("last", 32'(last), 32'(is_last));
                        check("odd", 32'(odd), 32'(is_last && len[0]));
                    end
                    holding = 1'b0;
                    hs_cyc = cyc;
                    wait_cnt = 0;
                end else begin
                    holding = 1'b1;
                    held = word;
                    held_last = last;
                    wait_cnt++;
                end
                ready = r;
            end else begin
                if (holding) check("valid_drop", 32'(valid), 32'd1);
                holding = 1'b0;
                ready = (mode == 0) ? 1'b1 : ((mode == 1) ? 1'($urandom_range(0, 1)) : 1'b0);
            end
            if (done) begin
                seen_done = 1'b1;
                check("done_cycle", 32'(cyc), 32'(hs_cyc + 1));
                check("words_left", 32'(exp_q.size()), 32'd0);
                check("reads_left", 32'(addr_q.size()), 32'd0);
                check("busy_in_done", 32'(busy), 32'd1);
            end else begin
                check("busy", 32'(busy), 32'd1);
            end
            @(posedge clk); #1;
            cyc++;
        end
        start = 1'b0;
        if (!seen_done) check("done_timeout", 32'(done), 32'd1);
        check("busy_after", 32'(busy), 32'd0);
        check("done_pulse", 32'(done), 32'd0);
        check("valid_after", 32'(valid), 32'd0);
        ready = 1'b0;
        @(posedge clk); #1;
    endtask

    // Abort on the second word's high-byte read (4th read of the transfer).
    task automatic do_abort();
        int reads;
        bit fired;
        reads = 0;
        fired = 1'b0;
        start = 1'b1;
        base_in = 12'd200;
        dlen = 16'd6;
        dtt = 3'd0;
        ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int c = 0; c < 40 && !fired; c++) begin
            if (rd_en) begin
                reads++;
                if (reads == 4) begin
                    check("abort_rdhi_addr", 32'(rd_addr), 32'd203);
                    abort = 1'b1;
                    fired = 1'b1;
                end
            end
            @(posedge clk); #1;
        end
        abort = 1'b0;
        if (!fired) check("abort_reach", 32'(reads), 32'd4);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_valid", 32'(valid), 32'd0);
        check("abort_rd_en", 32'(rd_en), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        for (int c = 0; c < 4; c++) begin
            @(posedge clk); #1;
            check("abort_quiet_done", 32'(done), 32'd0);
            check("abort_quiet_busy", 32'(busy), 32'd0);
            check("abort_quiet_rd", 32'(rd_en), 32'd0);
        end
        ready = 1'b0;
    endtask

    // Time limit in case the DUT wedges somewhere unbounded.
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Directed sequence followed by randomized transfers.
    initial begin
        logic [11:0] rb;
        logic [15:0] rl;
        logic [2:0]  rt;
        int          rm;

        for (int i = 0; i < 4096; i++) mem[i] = 8'($urandom);

        #1;
        check("rst_valid", 32'(valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_rd_en", 32'(rd_en), 32'd0);
        check("rst_addr", 32'(rd_addr), 32'd0);
        check("rst_word", 32'(word), 32'd0);
        check("rst_last", 32'(last), 32'd0);
        check("rst_odd", 32'(odd), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        mem[100] = 8'h11; mem[101] = 8'h22; mem[102] = 8'h33; mem[103] = 8'h44;
        do_transfer(12'd100, 16'd4, 3'd0, 0, 1'b1);

        mem[100] = 8'hA1; mem[101] = 8'hB2; mem[102] = 8'hC3;
        do_transfer(12'd100, 16'd3, 3'd0, 0, 1'b0);

        mem[300] = 8'h5A; mem[301] = 8'hA5;
        do_transfer(12'd300, 16'd0, 3'd2, 0, 1'b0);
        do_transfer(12'd300, 16'd0, 3'd0, 0, 1'b0);

        do_transfer(12'd100, 16'd4, 3'd0, 2, 1'b0);

        mem[4094] = 8'hDE; mem[4095] = 8'hAD; mem[0] = 8'hBE; mem[1] = 8'hEF;
        do_transfer(12'd4094, 16'd4, 3'd0, 0, 1'b0);

        do_abort();
        do_transfer(12'd100, 16'd3, 3'd7, 1, 1'b0);

        for (int t = 0; t < 25; t++) begin
            rb = 12'($urandom);
            rl = ($urandom_range(0, 3) == 0) ? 16'd0 : 16'($urandom_range(1, 11));
            rt = 3'($urandom);
            rm = int'($urandom_range(0, 2));
            for (int i = 0; i < 12; i++) mem[12'(rb + 12'(i))] = 8'($urandom);
            do_transfer(rb, rl, rt, rm, 1'($urandom_range(0, 1)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
